// File: rtl/motion_morph_pkg.sv
// Shared types and sizes for the 7x7 motion morphology / bounding-box block.
//  morph_mode_e : filter selection carried on the 2-bit mode input
//  WIN_N        : window edge length (7)
//  SUM_W        : width of the 0..49 ones-count
//  COORD_W      : width of pixel/line coordinates
package motion_morph_pkg;

  localparam int WIN_N     = 7;
  localparam int SUM_W     = 6;
  localparam int COORD_W   = 10;
  localparam int ROW_CNT_W = 3;

  typedef enum logic [1:0] {
    MORPH_ERODE  = 2'b00,
    MORPH_DILATE = 2'b01,
    MORPH_MAJ    = 2'b10,
    MORPH_BYPASS = 2'b11
  } morph_mode_e;

  // Ones-count of a completely filled window
  localparam logic [SUM_W-1:0] FULL_SUM = SUM_W'(WIN_N * WIN_N);

endpackage

// File: rtl/popcnt7.sv
// Combinational population count of one 7-bit window row.
//  bits  in  7  row of the binary window
//  count out 3  number of ones in the row (0..7)
module popcnt7
  import motion_morph_pkg::*;
(
  input  logic [WIN_N-1:0]     bits,
  output logic [ROW_CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIN_N; i++) begin
      count = count + {{(ROW_CNT_W-1){1'b0}}, bits[i]};
    end
  end

endmodule

// File: rtl/motion_morph_box_7.sv
// Morphological filter on a 7x7 binary window plus per-frame motion statistics.
// A free-running 3-stage pipeline (row counts, window sum, compare) produces the
// filtered bit with the frame syncs delayed alongside it. On the post stream the
// block tracks pixel coordinates, accumulates the bounding box and ones-count of
// the filtered bitmap, and publishes them one clock after post vsync falls.
//  clk, rst_n                      pixel clock, asynchronous active-low reset
//  mode                            00 erode, 01 dilate, 10 majority, 11 bypass
//  matrix_frame_vsync/href/clken   input frame syncs and pixel strobe
//  matrix[6:0][6:0]                binary window, centre matrix[3][3]
//  post_frame_vsync/href/clken     syncs delayed 3 clk
//  post_img_Bit                    filtered pixel, 0 outside active line
//  box_x_min/x_max/y_min/y_max     bounding box of last completed frame
//  motion_cnt, box_valid           ones-count of last frame, count != 0
//  frame_done                      1-clk pulse when the published values update
module motion_morph_box_7
  import motion_morph_pkg::*;
#(
  parameter logic [COORD_W-1:0] IMG_HDISP = 10'd640,
  parameter logic [COORD_W-1:0] IMG_VDISP = 10'd480,
  parameter logic [SUM_W-1:0]   THRESH    = 6'd25,
  parameter int                 CNT_W     = 19
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic               matrix_frame_vsync,
  input  logic               matrix_frame_href,
  input  logic               matrix_frame_clken,
  input  logic               matrix [WIN_N-1:0][WIN_N-1:0],
  output logic               post_frame_vsync,
  output logic               post_frame_href,
  output logic               post_frame_clken,
  output logic               post_img_Bit,
  output logic [COORD_W-1:0] box_x_min,
  output logic [COORD_W-1:0] box_x_max,
  output logic [COORD_W-1:0] box_y_min,
  output logic [COORD_W-1:0] box_y_max,
  output logic [CNT_W-1:0]   motion_cnt,
  output logic               box_valid,
  output logic               frame_done
);

  localparam logic [COORD_W-1:0] X_LIM = IMG_HDISP - COORD_W'(1);
  localparam logic [COORD_W-1:0] Y_LIM = IMG_VDISP - COORD_W'(1);

  function automatic logic [COORD_W-1:0] sat_inc_coord(input logic [COORD_W-1:0] v,
                                                       input logic [COORD_W-1:0] lim);
    return (v >= lim) ? lim : v + COORD_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic morph_decide(input logic [SUM_W-1:0] sum,
                                        input logic             centre,
                                        input morph_mode_e      m);
    logic r;
    case (m)
      MORPH_ERODE:  r = (sum == FULL_SUM);
      MORPH_DILATE: r = (sum != '0);
      MORPH_MAJ:    r = (sum >= THRESH);
      default:      r = centre;
    endcase
    return r;
  endfunction

  logic [WIN_N-1:0]     row_bits [WIN_N];
  logic [ROW_CNT_W-1:0] row_cnt  [WIN_N];

  for (genvar r = 0; r < WIN_N; r++) begin : g_row
    for (genvar c = 0; c < WIN_N; c++) begin : g_col
      assign row_bits[r][c] = matrix[r][c];
    end
    popcnt7 u_popcnt (
      .bits  (row_bits[r]),
      .count (row_cnt[r])
    );
  end

  // Mode is only taken at the start of an input frame so a frame is filtered
  // with one operator throughout.
  logic        in_vsync_d;
  morph_mode_e mode_r;

  logic [ROW_CNT_W-1:0] row_cnt_p0 [WIN_N];
  logic                 centre_p0, vsync_p0, href_p0, vld_p0;
  logic [SUM_W-1:0]     sum_p1;
  logic                 centre_p1, vsync_p1, href_p1, vld_p1;
  logic                 bit_p2, vsync_p2, href_p2, vld_p2;
  logic [SUM_W-1:0]     sum_s2;

  always_comb begin
    sum_s2 = '0;
    for (int r = 0; r < WIN_N; r++) begin
      sum_s2 = sum_s2 + SUM_W'(row_cnt_p0[r]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vsync_d <= 1'b0;
      mode_r     <= MORPH_ERODE;
      for (int r = 0; r < WIN_N; r++) row_cnt_p0[r] <= '0;
      centre_p0 <= 1'b0; vsync_p0 <= 1'b0; href_p0 <= 1'b0; vld_p0 <= 1'b0;
      sum_p1    <= '0;   centre_p1 <= 1'b0; vsync_p1 <= 1'b0; href_p1 <= 1'b0; vld_p1 <= 1'b0;
      bit_p2    <= 1'b0; vsync_p2 <= 1'b0; href_p2 <= 1'b0; vld_p2 <= 1'b0;
    end else begin
      in_vsync_d <= matrix_frame_vsync;
      if (matrix_frame_vsync && !in_vsync_d) mode_r <= morph_mode_e'(mode);
      // Stage 1: per-row ones-count
      for (int r = 0; r < WIN_N; r++) row_cnt_p0[r] <= row_cnt[r];
      centre_p0 <= matrix[3][3];
      vsync_p0  <= matrix_frame_vsync;
      href_p0   <= matrix_frame_href;
      vld_p0    <= matrix_frame_clken;
      // Stage 2: window sum
      sum_p1    <= sum_s2;
      centre_p1 <= centre_p0;
      vsync_p1  <= vsync_p0;
      href_p1   <= href_p0;
      vld_p1    <= vld_p0;
      // Stage 3: operator decision, blanked outside the active line
      bit_p2    <= href_p1 ? morph_decide(sum_p1, centre_p1, mode_r) : 1'b0;
      vsync_p2  <= vsync_p1;
      href_p2   <= href_p1;
      vld_p2    <= vld_p1;
    end
  end

  assign post_frame_vsync = vsync_p2;
  assign post_frame_href  = href_p2;
  assign post_frame_clken = vld_p2;
  assign post_img_Bit     = bit_p2;

  // Post-stream coordinates and statistics
  logic               post_vsync_d, post_href_d, publish_pend;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic [COORD_W-1:0] wx_min, wx_max, wy_min, wy_max;
  logic [CNT_W-1:0]   wcnt;
  logic [COORD_W-1:0] nx_min, nx_max, ny_min, ny_max;
  logic [CNT_W-1:0]   ncnt;
  logic               vs_rise, vs_fall, href_fall, hit;

  assign vs_rise   =  vsync_p2 && !post_vsync_d;
  assign vs_fall   = !vsync_p2 &&  post_vsync_d;
  assign href_fall = !href_p2  &&  post_href_d;
  assign hit       =  vld_p2 && href_p2 && bit_p2;

  // A frame start reinitialises the working set; a hit on that same clock is
  // still folded in.
  always_comb begin
    nx_min = vs_rise ? '1 : wx_min;
    nx_max = vs_rise ? '0 : wx_max;
    ny_min = vs_rise ? '1 : wy_min;
    ny_max = vs_rise ? '0 : wy_max;
    ncnt   = vs_rise ? '0 : wcnt;
    if (hit) begin
      if (x_cnt < nx_min) nx_min = x_cnt;
      if (x_cnt > nx_max) nx_max = x_cnt;
      if (y_cnt < ny_min) ny_min = y_cnt;
      if (y_cnt > ny_max) ny_max = y_cnt;
      ncnt = sat_inc_cnt(ncnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_vsync_d <= 1'b0;
      post_href_d  <= 1'b0;
      publish_pend <= 1'b0;
      x_cnt  <= '0;  y_cnt  <= '0;
      wx_min <= '1;  wx_max <= '0;
      wy_min <= '1;  wy_max <= '0;
      wcnt   <= '0;
      box_x_min <= '0; box_x_max <= '0;
      box_y_min <= '0; box_y_max <= '0;
      motion_cnt <= '0;
      box_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      post_vsync_d <= vsync_p2;
      post_href_d  <= href_p2;
      publish_pend <= vs_fall;

      if (href_fall)               x_cnt <= '0;
      else if (vld_p2 && href_p2)  x_cnt <= sat_inc_coord(x_cnt, X_LIM);

      if (vs_rise)                 y_cnt <= '0;
      else if (href_fall)          y_cnt <= sat_inc_coord(y_cnt, Y_LIM);

      wx_min <= nx_min; wx_max <= nx_max;
      wy_min <= ny_min; wy_max <= ny_max;
      wcnt   <= ncnt;

      // Publishing one clock after the fall lets a pixel on the fall clock land
      // in the working set first.
      if (publish_pend) begin
        box_x_min  <= wx_min; box_x_max <= wx_max;
        box_y_min  <= wy_min; box_y_max <= wy_max;
        motion_cnt <= wcnt;
        box_valid  <= (wcnt != '0);
        frame_done <= 1'b1;
      end else begin
        frame_done <= 1'b0;
      end
    end
  end

endmodule
